// File: rtl/brick_pkg.sv
// Shared constants and types for the keyboard front end
// and the paddle command interface.
package brick_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [7:0] CMD_RIGHT = 8'h00;
  localparam logic [7:0] CMD_LEFT  = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } kbd_state_e;

  typedef struct packed {
    logic space;
    logic right;
    logic left;
  } keys_t;

  function automatic keys_t key_map(
    input logic       ext,
    input logic [7:0] code
  );
    keys_t k;
    k.left  = ext ? (code == SC_LEFT) : (code == SC_A);
    k.right = ext ? (code == SC_RIGHT) : (code == SC_D);
    k.space = !ext && (code == SC_SPACE);
    return k;
  endfunction

endpackage

// File: rtl/ps2_paddle_keys_if.sv
// Keyboard pins in, paddle command pair and status pulses out.
interface ps2_paddle_keys_if;

  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] out;
  logic       outEnable;
  logic       launch;
  logic       frame_error;

  modport master (
    input  ps2_clk, ps2_dat,
    output out, outEnable, launch, frame_error
  );

  modport slave (
    output ps2_clk, ps2_dat,
    input  out, outEnable, launch, frame_error
  );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 receiver: sync, clock glitch filter, 11-bit framing,
// odd parity check and partial-frame timeout.
module ps2_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_s;
  logic [1:0]    dat_s;
  logic          filt;
  logic          filt_d;
  logic [FW-1:0] f_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    sh;
  logic [TW-1:0] to_cnt;
  logic          fall;
  logic          good;

  assign fall = filt_d & ~filt;
  // sh[0] = start, sh[8:1] = data, sh[9] = parity
  assign good = ~sh[0] & dat_s[1] & (^sh[9:1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s       <= 2'b11;
      dat_s       <= 2'b11;
      filt        <= 1'b1;
      filt_d      <= 1'b1;
      f_cnt       <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      to_cnt      <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_error <= 1'b0;
    end else begin
      clk_s       <= {clk_s[0], ps2_clk};
      dat_s       <= {dat_s[0], ps2_dat};
      filt_d      <= filt;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;

      if (clk_s[1] == filt) begin
        f_cnt <= '0;
      end else if (f_cnt == FW'(FILTER_LEN - 1)) begin
        filt  <= clk_s[1];
        f_cnt <= '0;
      end else begin
        f_cnt <= f_cnt + FW'(1);
      end

      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (good) begin
            byte_valid <= 1'b1;
            byte_data  <= sh[8:1];
          end else begin
            frame_error <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          sh      <= {dat_s[1], sh[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TW'(TIMEOUT)) begin
          bit_cnt     <= '0;
          to_cnt      <= '0;
          frame_error <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_paddle_keys.sv
// Scancode decoder: make/break FSM, held-key flags and
// registered paddle command outputs.
module ps2_paddle_keys
  import brick_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 100000
) (
  input logic              clock,
  input logic              reset,
  ps2_paddle_keys_if.master bus
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_err;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (bus.ps2_clk),
    .ps2_dat    (bus.ps2_dat),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(rx_err)
  );

  kbd_state_e state;
  logic       left_held;
  logic       right_held;
  logic       space_held;
  logic       launch_req;
  logic [7:0] cmd;
  logic       cmd_en;
  logic       launch_q;
  logic       ext;
  logic       pfx;
  logic       make;
  logic       brk;
  keys_t      key;

  assign ext  = (state == EXT) || (state == EXT_BRK);
  assign key  = key_map(ext, byte_data);
  assign pfx  = (byte_data == SC_EXT) || (byte_data == SC_BRK);
  assign make = byte_valid &&
                ((state == IDLE && !pfx) ||
                 (state == EXT && byte_data != SC_BRK));
  assign brk  = byte_valid &&
                (state == BRK || state == EXT_BRK);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      left_held  <= 1'b0;
      right_held <= 1'b0;
      space_held <= 1'b0;
      launch_req <= 1'b0;
      cmd        <= CMD_RIGHT;
      cmd_en     <= 1'b0;
      launch_q   <= 1'b0;
    end else begin
      launch_req <= 1'b0;
      if (make) begin
        left_held  <= left_held | key.left;
        right_held <= right_held | key.right;
        space_held <= space_held | key.space;
        // typematic repeats of space must not relaunch
        launch_req <= key.space & ~space_held;
      end
      if (brk) begin
        left_held  <= left_held & ~key.left;
        right_held <= right_held & ~key.right;
        space_held <= space_held & ~key.space;
      end
      if (byte_valid) begin
        unique case (state)
          IDLE: begin
            if (byte_data == SC_EXT)
              state <= EXT;
            else if (byte_data == SC_BRK)
              state <= BRK;
          end
          EXT: begin
            if (byte_data == SC_BRK)
              state <= EXT_BRK;
            else
              state <= IDLE;
          end
          BRK:     state <= IDLE;
          EXT_BRK: state <= IDLE;
        endcase
      end
      launch_q <= launch_req;
      cmd_en   <= left_held ^ right_held;
      if (left_held && !right_held)
        cmd <= CMD_LEFT;
      else
        cmd <= CMD_RIGHT;
    end
  end

  assign bus.out         = cmd;
  assign bus.outEnable   = cmd_en;
  assign bus.launch      = launch_q;
  assign bus.frame_error = rx_err;

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// Scoreboard bench: expected output events are queued as frames
// are driven and popped as the DUT produces them.
module tb_ps2_paddle_keys;
  import brick_pkg::*;

  localparam int FL = 4;
  localparam int TO = 2000;

  typedef enum int {EV_NONE, EV_CMD, EV_LAUNCH, EV_FERR} ev_e;
  typedef struct {
    ev_e        kind;
    logic [8:0] val;
    int         lat;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ps2_paddle_keys_if bus();

  ps2_paddle_keys #(
    .FILTER_LEN(FL),
    .TIMEOUT   (TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  ev_t        sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_stop = 0;
  logic       mon_on = 1'b0;
  logic [8:0] prev_cmd = 9'h0;

  always @(posedge clock) cyc++;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(
    input ev_e        k,
    input logic [8:0] v,
    input int         lat
  );
    sb.push_back('{k, v, lat});
  endtask

  task automatic take(input ev_e k, input logic [8:0] v);
    ev_t e;
    if (sb.size() == 0) begin
      check("spurious_event", k, EV_NONE);
      return;
    end
    e = sb.pop_front();
    check("event_kind", k, e.kind);
    check("event_value", v, e.val);
    if (e.lat != 0)
      check("event_latency", cyc - last_stop, e.lat);
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      if (bus.frame_error === 1'b1) take(EV_FERR, 9'h0);
      if (bus.launch === 1'b1) take(EV_LAUNCH, 9'h0);
      if ({bus.outEnable, bus.out} !== prev_cmd) begin
        prev_cmd = {bus.outEnable, bus.out};
        take(EV_CMD, prev_cmd);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [10:0] mk(
    input logic [7:0] b,
    input logic       bad
  );
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_dat = f[i];
      wait_n(5);
      bus.ps2_clk = 1'b0;
      if (i == 10) last_stop = cyc;
      wait_n(10);
      bus.ps2_clk = 1'b1;
      wait_n(5);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic bad);
    send_bits(mk(b, bad), 11);
    bus.ps2_dat = 1'b1;
    wait_n(30);
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_out"}, bus.out, 8'h00);
    check({tag, "_en"}, bus.outEnable, 1'b0);
    check({tag, "_launch"}, bus.launch, 1'b0);
    check({tag, "_ferr"}, bus.frame_error, 1'b0);
  endtask

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    wait_n(4);
    reset = 1'b0;
    wait_n(1);
    check_rst("reset");
    mon_on = 1'b1;
    wait_n(3000);

    // right arrow make then break
    send(SC_EXT, 0);
    push(EV_CMD, {1'b1, CMD_RIGHT}, 9);
    send(SC_RIGHT, 0);
    send(SC_EXT, 0);
    send(SC_BRK, 0);
    push(EV_CMD, 9'h0, 9);
    send(SC_RIGHT, 0);

    // A plus right arrow, then release A
    push(EV_CMD, {1'b1, CMD_LEFT}, 9);
    send(SC_A, 0);
    send(SC_EXT, 0);
    push(EV_CMD, 9'h0, 9);
    send(SC_RIGHT, 0);
    send(SC_BRK, 0);
    push(EV_CMD, {1'b1, CMD_RIGHT}, 9);
    send(SC_A, 0);
    send(SC_EXT, 0);
    send(SC_BRK, 0);
    push(EV_CMD, 9'h0, 9);
    send(SC_RIGHT, 0);

    // space typematic: one launch per press
    push(EV_LAUNCH, 9'h0, 9);
    send(SC_SPACE, 0);
    send(SC_SPACE, 0);
    send(SC_SPACE, 0);
    send(SC_BRK, 0);
    send(SC_SPACE, 0);
    push(EV_LAUNCH, 9'h0, 9);
    send(SC_SPACE, 0);
    send(SC_BRK, 0);
    send(SC_SPACE, 0);

    // bad parity, and a bad frame must not disturb EXT
    push(EV_FERR, 9'h0, 7);
    send(SC_LEFT, 1);
    send(SC_EXT, 0);
    push(EV_FERR, 9'h0, 7);
    send(SC_LEFT, 1);
    push(EV_CMD, {1'b1, CMD_RIGHT}, 9);
    send(SC_RIGHT, 0);
    send(SC_EXT, 0);
    send(SC_BRK, 0);
    push(EV_CMD, 9'h0, 9);
    send(SC_RIGHT, 0);

    // partial frame times out, next frame is clean
    push(EV_FERR, 9'h0, 0);
    send_bits(mk(SC_A, 0), 5);
    wait_n(TO + 200);
    check("timeout_seen", sb.size(), 0);
    push(EV_CMD, {1'b1, CMD_LEFT}, 9);
    send(SC_A, 0);

    // reset mid-frame while left is held
    send_bits(mk(SC_D, 0), 3);
    push(EV_CMD, 9'h0, 0);
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    check_rst("midreset");
    wait_n(2);
    push(EV_CMD, {1'b1, CMD_RIGHT}, 9);
    send(SC_D, 0);

    wait_n(100);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
